rs_decoder_lane_scheduler: RTL and testbench



---
 rtl/rs_decoder_lane_scheduler.sv | 157 +++++++++++++++
 tb/tb_rs_decoder_lane_scheduler.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_decoder_lane_scheduler.sv
// Round-robin scheduler sharing N_LANES Reed-Solomon decoder lanes; results retire in issue order.
// Optional per-lane busy watchdog: define RS_SCHED_WATCHDOG_EN (adds err_timeout / timeout_lanes).
module rs_decoder_lane_scheduler #(
    parameter int N_LANES = 4,
    parameter int DATA_W  = 512,
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [DATA_W-1:0]           in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [N_LANES*DATA_W-1:0]   lane_data,
    output logic [N_LANES-1:0]          lane_valid,
    input  logic [N_LANES*DATA_W-1:0]   lane_result,
    input  logic [N_LANES-1:0]          lane_result_valid,
    output logic [DATA_W-1:0]           out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [CNT_W-1:0]            blocks_issued,
    output logic [CNT_W-1:0]            blocks_retired,
    output logic                        idle,
`ifdef RS_SCHED_WATCHDOG_EN
    output logic                        err_timeout,
    output logic [N_LANES-1:0]          timeout_lanes,
`endif
    output logic                        err_spurious
);

    localparam int PW = $clog2(N_LANES);

    if (N_LANES < 2 || N_LANES > 16 || (N_LANES & (N_LANES - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
        $error("rs_decoder_lane_scheduler: unsupported N_LANES or TIMEOUT");
    end

    typedef enum logic [1:0] {
        LANE_FREE = 2'd0,
        LANE_BUSY = 2'd1,
        LANE_DONE = 2'd2
    } lane_state_t;

    lane_state_t                state_r [N_LANES];
    logic [DATA_W-1:0]          buf_r   [N_LANES];
    logic [PW-1:0]              iptr_r;
    logic [PW-1:0]              rptr_r;
    logic [N_LANES*DATA_W-1:0]  lane_data_r;
    logic [N_LANES-1:0]         lane_valid_r;
    logic [CNT_W-1:0]           issued_r;
    logic [CNT_W-1:0]           retired_r;
    logic                       err_spurious_r;
    logic                       in_ready_s;
    logic                       out_valid_s;
    logic                       issue_s;
    logic                       retire_s;
    logic                       idle_s;

`ifdef RS_SCHED_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0]            wd_cnt_r [N_LANES];
    logic                       err_timeout_r;
    logic [N_LANES-1:0]         timeout_lanes_r;

    assign err_timeout   = err_timeout_r;
    assign timeout_lanes = timeout_lanes_r;
`endif

    // Handshake and status decode, all derived from registered lane state
    always_comb begin
        in_ready_s  = enable && (state_r[iptr_r] == LANE_FREE);
        out_valid_s = (state_r[rptr_r] == LANE_DONE);
        issue_s     = in_valid && in_ready_s;
        retire_s    = out_valid_s && out_ready;
        idle_s      = 1'b1;
        for (int i = 0; i < N_LANES; i++) begin
            idle_s = idle_s && (state_r[i] == LANE_FREE);
        end
    end

    assign in_ready       = in_ready_s;
    assign out_valid      = out_valid_s;
    assign out_data       = buf_r[rptr_r];
    assign idle           = idle_s;
    assign lane_data      = lane_data_r;
    assign lane_valid     = lane_valid_r;
    assign blocks_issued  = issued_r;
    assign blocks_retired = retired_r;
    assign err_spurious   = err_spurious_r;

    // Lane state machines, pointers, result capture and statistics
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_LANES; i++) begin
                state_r[i] <= LANE_FREE;
                buf_r[i]   <= '0;
`ifdef RS_SCHED_WATCHDOG_EN
                wd_cnt_r[i] <= '0;
`endif
            end
            iptr_r         <= '0;
            rptr_r         <= '0;
            lane_data_r    <= '0;
            lane_valid_r   <= '0;
            issued_r       <= '0;
            retired_r      <= '0;
            err_spurious_r <= 1'b0;
`ifdef RS_SCHED_WATCHDOG_EN
            err_timeout_r   <= 1'b0;
            timeout_lanes_r <= '0;
`endif
        end else begin
            lane_valid_r <= '0;
            if (issue_s) begin
                iptr_r   <= iptr_r + PW'(1);
                issued_r <= issued_r + CNT_W'(1);
            end
            if (retire_s) begin
                rptr_r    <= rptr_r + PW'(1);
                retired_r <= retired_r + CNT_W'(1);
            end
            // Issue needs FREE, capture needs BUSY, retire needs DONE: never two on one lane
            for (int i = 0; i < N_LANES; i++) begin
                if (issue_s && (iptr_r == PW'(i))) begin
                    state_r[i]                      <= LANE_BUSY;
                    lane_data_r[i*DATA_W +: DATA_W] <= in_data;
                    lane_valid_r[i]                 <= 1'b1;
                end else if (retire_s && (rptr_r == PW'(i))) begin
                    state_r[i] <= LANE_FREE;
                end
                if (lane_result_valid[i]) begin
                    if (state_r[i] == LANE_BUSY) begin
                        buf_r[i]   <= lane_result[i*DATA_W +: DATA_W];
                        state_r[i] <= LANE_DONE;
                    end else begin
                        err_spurious_r <= 1'b1;
                    end
                end
`ifdef RS_SCHED_WATCHDOG_EN
                if (issue_s && (iptr_r == PW'(i))) begin
                    wd_cnt_r[i] <= '0;
                end else if (state_r[i] == LANE_BUSY && !lane_result_valid[i]) begin
                    if (wd_cnt_r[i] == WD_W'(TIMEOUT)) begin
                        state_r[i]         <= LANE_DONE;
                        buf_r[i]           <= '0;
                        err_timeout_r      <= 1'b1;
                        timeout_lanes_r[i] <= 1'b1;
                    end else begin
                        wd_cnt_r[i] <= wd_cnt_r[i] + WD_W'(1);
                    end
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_rs_decoder_lane_scheduler.sv
// Bench for rs_decoder_lane_scheduler: directed table, hand sequences and random traffic
// checked against an in-order queue model of outstanding blocks.
module tb_rs_decoder_lane_scheduler;
    localparam int N  = 4;
    localparam int DW = 512;
    localparam int CW = 32;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            enable = 1'b0;
    logic [DW-1:0]   in_data = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [N*DW-1:0] lane_data;
    logic [N-1:0]    lane_valid;
    logic [N*DW-1:0] lane_result = '0;
    logic [N-1:0]    lane_result_valid = '0;
    logic [DW-1:0]   out_data;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [CW-1:0]   blocks_issued;
    logic [CW-1:0]   blocks_retired;
    logic            idle;
    logic            err_spurious;
`ifdef RS_SCHED_WATCHDOG_EN
    logic            err_timeout;
    logic [N-1:0]    timeout_lanes;
`endif

    rs_decoder_lane_scheduler #(.N_LANES(N), .DATA_W(DW), .CNT_W(CW), .TIMEOUT(1024)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .lane_data(lane_data), .lane_valid(lane_valid),
        .lane_result(lane_result), .lane_result_valid(lane_result_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .blocks_issued(blocks_issued), .blocks_retired(blocks_retired),
        .idle(idle),
`ifdef RS_SCHED_WATCHDOG_EN
        .err_timeout(err_timeout), .timeout_lanes(timeout_lanes),
`endif
        .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: queue of outstanding blocks in issue order; lanes are handed out cyclically.
    typedef struct {
        int            lane;
        bit            done;
        logic [DW-1:0] res;
    } ent_t;

    ent_t          q[$];
    int            next_lane;
    logic [DW-1:0] m_lane_data [N];
    logic [N-1:0]  m_lane_valid;
    int unsigned   m_issued;
    int unsigned   m_retired;
    bit            m_err;

    function automatic void model_reset();
        q.delete();
        next_lane    = 0;
        m_lane_valid = '0;
        m_issued     = 0;
        m_retired    = 0;
        m_err        = 1'b0;
        for (int i = 0; i < N; i++) m_lane_data[i] = '0;
    endfunction

    function automatic logic [DW-1:0] rand_blk();
        logic [DW-1:0] r;
        for (int k = 0; k < DW / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    // One clock cycle: compare at negedge, advance the model, return at posedge+1.
    task automatic step();
        bit e_rdy;
        bit e_ov;
        @(negedge clk);
        e_rdy = enable && (q.size() < N);
        e_ov  = (q.size() > 0) && q[0].done;
        chk("in_ready", in_ready, e_rdy);
        chk("out_valid", out_valid, e_ov);
        if (e_ov) chk("out_data", out_data, q[0].res);
        chk("idle", idle, q.size() == 0);
        chk("lane_valid", lane_valid, m_lane_valid);
        chk("blocks_issued", blocks_issued, m_issued);
        chk("blocks_retired", blocks_retired, m_retired);
        chk("err_spurious", err_spurious, m_err);
        for (int i = 0; i < N; i++) chk("lane_data", lane_data[i*DW +: DW], m_lane_data[i]);
        for (int i = 0; i < N; i++) begin
            if (lane_result_valid[i]) begin
                int hit;
                hit = -1;
                foreach (q[j]) if (q[j].lane == i && !q[j].done) hit = j;
                if (hit >= 0) begin
                    ent_t e;
                    e      = q[hit];
                    e.done = 1'b1;
                    e.res  = lane_result[i*DW +: DW];
                    q[hit] = e;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
        if (e_ov && out_ready) begin
            void'(q.pop_front());
            m_retired++;
        end
        m_lane_valid = '0;
        if (in_valid && e_rdy) begin
            ent_t e;
            e.lane = next_lane;
            e.done = 1'b0;
            e.res  = '0;
            q.push_back(e);
            m_lane_data[next_lane]  = in_data;
            m_lane_valid[next_lane] = 1'b1;
            next_lane = (next_lane + 1) % N;
            m_issued++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_res(input logic [N-1:0] v, input logic [7:0] b);
        lane_result_valid = v;
        for (int i = 0; i < N; i++) if (v[i]) lane_result[i*DW +: DW] = {64{b}};
    endtask

    task automatic do_reset();
        reset = 1'b1;
        enable = 1'b0; in_valid = 1'b0; out_ready = 1'b0; lane_result_valid = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit         en;
        bit         iv;
        logic [7:0] d;
        bit         ordy;
        logic [3:0] rv;
        logic [7:0] rb;
        bit         e_rdy;
        bit         e_ov;
        logic [7:0] e_ob;
        bit         e_idle;
    } vec_t;

    vec_t tbl [19];

    initial begin
        // Out-of-order completion, full pipeline, backpressure and refill of lane 0
        tbl[0]  = '{1, 1, 8'h11, 0, 4'b0000, 8'h00, 1, 0, 8'h00, 1};
        tbl[1]  = '{1, 1, 8'h12, 0, 4'b0000, 8'h00, 1, 0, 8'h00, 0};
        tbl[2]  = '{1, 1, 8'h13, 0, 4'b0000, 8'h00, 1, 0, 8'h00, 0};
        tbl[3]  = '{1, 1, 8'h14, 0, 4'b0000, 8'h00, 1, 0, 8'h00, 0};
        tbl[4]  = '{1, 1, 8'h15, 0, 4'b0000, 8'h00, 0, 0, 8'h00, 0};
        tbl[5]  = '{1, 1, 8'h15, 0, 4'b1000, 8'hC4, 0, 0, 8'h00, 0};
        tbl[6]  = '{1, 1, 8'h15, 0, 4'b0100, 8'hC3, 0, 0, 8'h00, 0};
        tbl[7]  = '{1, 1, 8'h15, 0, 4'b0010, 8'hC2, 0, 0, 8'h00, 0};
        tbl[8]  = '{1, 1, 8'h15, 0, 4'b0001, 8'hC1, 0, 0, 8'h00, 0};
        tbl[9]  = '{1, 1, 8'h15, 0, 4'b0000, 8'h00, 0, 1, 8'hC1, 0};
        tbl[10] = '{1, 1, 8'h15, 1, 4'b0000, 8'h00, 0, 1, 8'hC1, 0};
        tbl[11] = '{1, 1, 8'h15, 0, 4'b0000, 8'h00, 1, 1, 8'hC2, 0};
        tbl[12] = '{1, 0, 8'h00, 1, 4'b0000, 8'h00, 0, 1, 8'hC2, 0};
        tbl[13] = '{1, 0, 8'h00, 1, 4'b0000, 8'h00, 1, 1, 8'hC3, 0};
        tbl[14] = '{1, 0, 8'h00, 1, 4'b0000, 8'h00, 1, 1, 8'hC4, 0};
        tbl[15] = '{1, 0, 8'h00, 1, 4'b0000, 8'h00, 1, 0, 8'h00, 0};
        tbl[16] = '{1, 0, 8'h00, 1, 4'b0001, 8'hC5, 1, 0, 8'h00, 0};
        tbl[17] = '{1, 0, 8'h00, 1, 4'b0000, 8'h00, 1, 1, 8'hC5, 0};
        tbl[18] = '{1, 0, 8'h00, 1, 4'b0000, 8'h00, 1, 0, 8'h00, 1};

        model_reset();
        do_reset();
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_idle", idle, 1'b1);
        chk("rst_lane_valid", lane_valid, '0);
        chk("rst_issued", blocks_issued, '0);
        chk("rst_retired", blocks_retired, '0);
        chk("rst_err", err_spurious, 1'b0);

        // Single block through lane 0
        enable = 1'b1; in_valid = 1'b1; in_data = {64{8'hA5}};
        step();
        in_valid = 1'b0;
        chk("single_lane_valid", lane_valid, 4'b0001);
        chk("single_lane_data", lane_data[DW-1:0], {64{8'hA5}});
        step();
        chk("single_pulse_len", lane_valid, 4'b0000);
        repeat (7) step();
        set_res(4'b0001, 8'h5A);
        step();
        lane_result_valid = '0;
        chk("single_out_valid", out_valid, 1'b1);
        chk("single_out_data", out_data, {64{8'h5A}});
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("single_issued", blocks_issued, 1);
        chk("single_retired", blocks_retired, 1);
        chk("single_idle", idle, 1'b1);

        do_reset();
        for (int r = 0; r < 19; r++) begin
            enable = tbl[r].en; in_valid = tbl[r].iv; in_data = {64{tbl[r].d}};
            out_ready = tbl[r].ordy;
            set_res(tbl[r].rv, tbl[r].rb);
            #1;
            chk("tbl_in_ready", in_ready, tbl[r].e_rdy);
            chk("tbl_out_valid", out_valid, tbl[r].e_ov);
            if (tbl[r].e_ov) chk("tbl_out_data", out_data, {64{tbl[r].e_ob}});
            chk("tbl_idle", idle, tbl[r].e_idle);
            step();
        end
        lane_result_valid = '0; out_ready = 1'b0;
        chk("tbl_issued", blocks_issued, 5);
        chk("tbl_retired", blocks_retired, 5);

        // Spurious pulse on a FREE lane
        do_reset();
        set_res(4'b0100, 8'hEE);
        step();
        lane_result_valid = '0;
        chk("spur_err", err_spurious, 1'b1);
        chk("spur_out_valid", out_valid, 1'b0);
        chk("spur_retired", blocks_retired, 0);

        // enable dropped after two issues, then resumed at lane 2
        do_reset();
        enable = 1'b1; in_valid = 1'b1; in_data = rand_blk();
        step();
        in_data = rand_blk();
        step();
        enable = 1'b0;
        step();
        chk("en_off_ready", in_ready, 1'b0);
        set_res(4'b0011, 8'h3C);
        step();
        lane_result_valid = '0; out_ready = 1'b1;
        step();
        step();
        out_ready = 1'b0;
        chk("en_off_retired", blocks_retired, 2);
        chk("en_off_issued", blocks_issued, 2);
        chk("en_off_idle", idle, 1'b1);
        enable = 1'b1; in_data = rand_blk();
        step();
        in_valid = 1'b0;
        chk("en_resume_lane", lane_valid, 4'b0100);

        // Asynchronous reset with lanes 0 and 1 busy
        do_reset();
        enable = 1'b1; in_valid = 1'b1; in_data = rand_blk();
        step();
        in_data = rand_blk();
        step();
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("arst_lane_valid", lane_valid, '0);
        for (int i = 0; i < N; i++) chk("arst_lane_data", lane_data[i*DW +: DW], '0);
        chk("arst_issued", blocks_issued, '0);
        chk("arst_idle", idle, 1'b1);
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_in_ready", in_ready, 1'b1);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        set_res(4'b0001, 8'h77);
        step();
        lane_result_valid = '0;
        chk("arst_late_spur", err_spurious, 1'b1);

        // Random traffic against the queue model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            enable    = ($urandom_range(0, 9) != 0);
            in_valid  = $urandom_range(0, 1);
            in_data   = rand_blk();
            out_ready = ($urandom_range(0, 3) != 0);
            lane_result_valid = '0;
            foreach (q[j]) begin
                if (!q[j].done && $urandom_range(0, 3) == 0) begin
                    lane_result_valid[q[j].lane] = 1'b1;
                    lane_result[q[j].lane*DW +: DW] = rand_blk();
                end
            end
            if (c > 2000 && $urandom_range(0, 199) == 0) begin
                lane_result_valid[$urandom_range(0, N - 1)] = 1'b1;
            end
            step();
        end
        lane_result_valid = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
